// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the execute stage and the data
// memory port. One transaction in flight: IDLE -> REQ -> WAIT -> RESP.
// Optional build macro: LSU_TIMEOUT_EN adds a REQ/WAIT watchdog that ends a
// stuck access with an error response after TIMEOUT_CYCLES cycles.
//
// Handshakes: every interface uses valid/ready. A transfer happens on a
// rising edge where both valid and ready are high. The sender holds its
// payload stable while valid is high and ready is low.
module lsu_ctrl
`ifdef LSU_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 64)
`endif
  (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        mem_valid,
   input  logic        mem_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_data,
   output logic        resp_err
   );

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   logic [1:0]  state;
   logic        lat_we;
   logic [2:0]  lat_op;
   logic [1:0]  lat_lo;

   logic        acc_misaligned;
   logic [3:0]  acc_strb;
   logic [31:0] acc_wdata;
   logic [31:0] load_data;
   logic        timed_out;

   assign req_ready = (state == S_IDLE);

   // Decode the incoming request: op[1:0]==00 byte, 01 half, else word.
   always_comb begin
      acc_misaligned = 1'b0;
      acc_strb       = 4'b1111;
      acc_wdata      = req_wdata;
      case (req_op[1:0])
         2'b00: begin
            acc_strb  = 4'b0001 << req_addr[1:0];
            acc_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            acc_misaligned = req_addr[0];
            acc_strb       = req_addr[1] ? 4'b1100 : 4'b0011;
            acc_wdata      = {2{req_wdata[15:0]}};
         end
         default: begin
            acc_misaligned = (req_addr[1:0] != 2'b00);
         end
      endcase
   end

   // Lane-select and extend read data using the latched op and address bits.
   always_comb begin
      logic [7:0]  byte_lane;
      logic [15:0] half_lane;
      byte_lane = 8'h00;
      case (lat_lo)
         2'd0:    byte_lane = mem_rdata[7:0];
         2'd1:    byte_lane = mem_rdata[15:8];
         2'd2:    byte_lane = mem_rdata[23:16];
         default: byte_lane = mem_rdata[31:24];
      endcase
      half_lane = lat_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (lat_op[1:0])
         2'b00:   load_data = {{24{byte_lane[7] & ~lat_op[2]}}, byte_lane};
         2'b01:   load_data = {{16{half_lane[15] & ~lat_op[2]}}, half_lane};
         default: load_data = mem_rdata;
      endcase
   end

`ifdef LSU_TIMEOUT_EN
   logic [31:0] to_cnt;

   assign timed_out = (to_cnt == 32'(TIMEOUT_CYCLES - 1));

   // Watchdog: restarts on entry to REQ or WAIT, counts every cycle there.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if ((state == S_IDLE) || (state == S_REQ && mem_ready)) begin
         to_cnt <= '0;
      end else if (state == S_REQ || state == S_WAIT) begin
         to_cnt <= to_cnt + 32'd1;
      end
   end
`else
   assign timed_out = 1'b0;
`endif

   // Transaction sequencer and registered memory/response outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         lat_we     <= 1'b0;
         lat_op     <= 3'b000;
         lat_lo     <= 2'b00;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wstrb  <= 4'b0000;
         mem_wdata  <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  lat_we <= req_we;
                  lat_op <= req_op;
                  lat_lo <= req_addr[1:0];
                  if (acc_misaligned) begin
                     // No memory access for a misaligned request.
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_data  <= '0;
                     state      <= S_RESP;
                  end else begin
                     mem_valid <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[31:2], 2'b00};
                     mem_wstrb <= req_we ? acc_strb : 4'b0000;
                     mem_wdata <= req_we ? acc_wdata : 32'h0;
                     state     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
                  if (lat_we) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b0;
                     resp_data  <= '0;
                     state      <= S_RESP;
                  end else begin
                     state <= S_WAIT;
                  end
               end else if (timed_out) begin
                  mem_valid  <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_data  <= '0;
                  state      <= S_RESP;
               end
            end
            S_WAIT: begin
               if (mem_rvalid) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_data  <= load_data;
                  state      <= S_RESP;
               end else if (timed_out) begin
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_data  <= '0;
                  state      <= S_RESP;
               end
            end
            default: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed checks of lsu_ctrl in the default build.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        mem_valid;
   logic        mem_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_data;
   logic        resp_err;

   int n_total = 0;
   int n_pass  = 0;

   lsu_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_op     (req_op),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_err   (resp_err)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   // Advance one rising edge; inputs are driven and outputs sampled 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req_ready"},  32'(req_ready),  32'd1);
      check({tag, "_mem_valid"},  32'(mem_valid),  32'd0);
      check({tag, "_mem_we"},     32'(mem_we),     32'd0);
      check({tag, "_mem_addr"},   mem_addr,        32'h0);
      check({tag, "_mem_wstrb"},  32'(mem_wstrb),  32'd0);
      check({tag, "_mem_wdata"},  mem_wdata,       32'h0);
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      check({tag, "_resp_data"},  resp_data,       32'h0);
      check({tag, "_resp_err"},   32'(resp_err),   32'd0);
   endtask

   // Present one request for a single accepting edge.
   task automatic issue(input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wdata);
      req_valid = 1'b1;
      req_we    = we;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      step();
      req_valid = 1'b0;
   endtask

   // Zero-wait load: accept at T, mem_ready at T+1, rvalid at T+2, response at T+3.
   task automatic do_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] rdata, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data);
      issue(1'b0, op, addr, 32'h0);
      check({tag, "_mem_valid"}, 32'(mem_valid), 32'd1);
      check({tag, "_mem_addr"},  mem_addr,       exp_addr);
      check({tag, "_mem_wstrb"}, 32'(mem_wstrb), 32'd0);
      check({tag, "_mem_we"},    32'(mem_we),    32'd0);
      check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check({tag, "_mem_valid_drop"}, 32'(mem_valid), 32'd0);
      check({tag, "_no_early_resp"},  32'(resp_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      check({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_resp_data"},  resp_data,       exp_data);
      check({tag, "_resp_err"},   32'(resp_err),   32'd0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check({tag, "_resp_done"}, 32'(resp_valid), 32'd0);
      check({tag, "_idle"},      32'(req_ready),  32'd1);
   endtask

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_op     = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      resp_ready = 1'b0;

      // Reset with stale rvalid present.
      step();
      step();
      check_reset_values("rst");
      rst_n = 1'b1;
      step();
      check("rst_stale_rvalid_resp", 32'(resp_valid), 32'd0);
      check("rst_stale_rvalid_idle", 32'(req_ready),  32'd1);
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;

      // Loads: LBU lane 3, LH upper half signed, LHU, LB signed lane 1, LW.
      do_load("lbu", 3'b100, 32'h0000_1003, 32'h80FF_1234, 32'h0000_1000, 32'h0000_0080);
      do_load("lh",  3'b001, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_2000, 32'hFFFF_8001);
      do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_7FFF, 32'h0000_2000, 32'h0000_8001);
      do_load("lb",  3'b000, 32'h0000_2101, 32'h0000_9A00, 32'h0000_2100, 32'hFFFF_FF9A);
      do_load("lw",  3'b010, 32'h0000_2204, 32'hCAFE_F00D, 32'h0000_2204, 32'hCAFE_F00D);
      do_load("lw_op7", 3'b111, 32'h0000_2208, 32'h1234_5678, 32'h0000_2208, 32'h1234_5678);

      // SB with mem_ready delayed: request held stable for four cycles.
      issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00AB);
      for (int i = 0; i < 4; i++) begin
         check("sb_hold_valid", 32'(mem_valid), 32'd1);
         check("sb_hold_we",    32'(mem_we),    32'd1);
         check("sb_hold_addr",  mem_addr,       32'h0000_3000);
         check("sb_hold_wstrb", 32'(mem_wstrb), 32'b0010);
         check("sb_hold_wdata", mem_wdata,      32'hABAB_ABAB);
         check("sb_hold_noresp", 32'(resp_valid), 32'd0);
         if (i == 3) mem_ready = 1'b1;
         step();
      end
      mem_ready = 1'b0;
      check("sb_mem_valid_drop", 32'(mem_valid),  32'd0);
      check("sb_resp_valid",     32'(resp_valid), 32'd1);
      check("sb_resp_data",      resp_data,       32'h0);
      check("sb_resp_err",       32'(resp_err),   32'd0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("sb_idle", 32'(req_ready), 32'd1);

      // SH upper half, zero-wait: response at T+2.
      issue(1'b1, 3'b001, 32'h0000_5002, 32'h1234_5678);
      check("sh_wstrb", 32'(mem_wstrb), 32'b1100);
      check("sh_wdata", mem_wdata,      32'h5678_5678);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      check("sh_resp_valid", 32'(resp_valid), 32'd1);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      // SW: full strobes, data unchanged.
      issue(1'b1, 3'b010, 32'h0000_6008, 32'h0BAD_CAFE);
      check("sw_wstrb", 32'(mem_wstrb), 32'b1111);
      check("sw_wdata", mem_wdata,      32'h0BAD_CAFE);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      // Misaligned LW: no memory access, error response one cycle after accept.
      issue(1'b0, 3'b010, 32'h0000_4002, 32'h0);
      for (int i = 0; i < 3; i++) begin
         check("mis_resp_valid", 32'(resp_valid), 32'd1);
         check("mis_resp_err",   32'(resp_err),   32'd1);
         check("mis_resp_data",  resp_data,       32'h0);
         check("mis_no_mem",     32'(mem_valid),  32'd0);
         check("mis_req_ready",  32'(req_ready),  32'd0);
         if (i == 2) begin
            // A new request offered alongside resp_ready must not be taken.
            resp_ready = 1'b1;
            req_valid  = 1'b1;
            req_we     = 1'b0;
            req_op     = 3'b010;
            req_addr   = 32'h0000_7000;
         end
         step();
      end
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      check("mis_done_resp",   32'(resp_valid), 32'd0);
      check("mis_done_idle",   32'(req_ready),  32'd1);
      check("mis_no_accept",   32'(mem_valid),  32'd0);

      // Misaligned LH (addr[0]=1) also errors.
      issue(1'b0, 3'b101, 32'h0000_4001, 32'h0);
      check("mish_resp_err", 32'(resp_err),  32'd1);
      check("mish_no_mem",   32'(mem_valid), 32'd0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;

      // Reset while in WAIT, then a late rvalid must not produce a response.
      issue(1'b0, 3'b010, 32'h0000_8000, 32'h0);
      mem_ready = 1'b1;
      step();
      mem_ready = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_reset_values("wrst");
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h5555_AAAA;
      step();
      mem_rvalid = 1'b0;
      check("wrst_late_rvalid_resp", 32'(resp_valid), 32'd0);
      check("wrst_late_rvalid_idle", 32'(req_ready),  32'd1);
      check("wrst_late_rvalid_data", resp_data,       32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store sequencing controller between the execute stage and the data memory port.
- Accepts one load/store request at a time and checks its alignment.
- Drives a valid/ready memory request with word-aligned address, byte strobes and lane-replicated write data.
- Waits for read data, then byte/half-extracts and sign/zero-extends it.
- Returns a single registered response to the pipeline.

Parameters:
TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only when LSU_TIMEOUT_EN is defined.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
req_valid  input  1  pipeline request valid
req_ready  output  1  controller can accept a request
req_we  input  1  1 = store, 0 = load
req_op  input  3  width/sign: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; other values treated as word
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
mem_valid  output  1  memory request valid
mem_ready  input  1  memory accepts request
mem_we  output  1  memory write enable
mem_addr  output  32  {addr[31:2],2'b00}
mem_wstrb  output  4  byte write enables (4'b0000 on loads)
mem_wdata  output  32  lane-replicated store data
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data word
resp_valid  output  1  response valid
resp_ready  input  1  pipeline consumes response
resp_data  output  32  extended load data; 0 for stores and errors
resp_err  output  1  misaligned access (or timeout)

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous, active-low.
- Reset values: state IDLE, req_ready=1, mem_valid=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0, resp_valid=0, resp_data=0, resp_err=0.
- All outputs are registered. Only req_ready is combinational: req_ready = (state==IDLE).
- States:
  - IDLE: request accepted when req_valid && req_ready. On acceptance, latch we, op, addr[1:0], wdata.
    - Misaligned request (half with addr[0]=1, or word with addr[1:0]!=0): go to RESP with resp_err=1, resp_data=0. No memory access is made.
    - Otherwise go to REQ.
  - REQ: mem_valid=1. mem_addr, mem_we, mem_wstrb and mem_wdata are held stable until mem_ready.
    - On mem_ready, store: go to RESP (err=0, data=0).
    - On mem_ready, load: go to WAIT.
  - WAIT: on mem_rvalid, register the extracted value and go to RESP.
    - Byte: lane addr[1:0]. Half: lane addr[1].
    - Signed ops extend the lane MSB; unsigned ops zero-fill.
  - RESP: resp_valid=1. Data and err are held until resp_ready, then return to IDLE.
    - No new request is accepted in the same cycle as resp_ready.
- Store strobes:
  - byte: 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}
  - half: 4'b0011<<(2*addr[1]), wdata = {2{wdata[15:0]}}
  - word: 4'b1111, wdata unchanged
- Latency, zero-wait memory, accept at cycle T:
  - mem_valid high at T+1.
  - Store: resp_valid at T+2.
  - Load with rvalid at T+2: resp_valid at T+3.
- mem_rvalid is ignored outside WAIT. This covers rvalid in the same cycle as mem_ready, and stale rvalid after reset.
- Only one transaction is outstanding; there is no buffering.
- rst_n low in any state forces the reset values at the next edge and abandons any in-flight memory request.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - A counter clears on entering REQ or WAIT and increments every cycle spent in REQ/WAIT.
  - When the count reaches TIMEOUT_CYCLES without mem_ready (REQ) or mem_rvalid (WAIT), go to RESP with resp_err=1, resp_data=0, and drop mem_valid.
- Undefined: no counter exists; the controller waits indefinitely.

Test Plan:
- LB unsigned at addr 0x1003, mem_rdata 0x80FF_1234 -> mem_addr 0x1000, wstrb 0000, resp_data 0x0000_0080, err 0.
- LH signed at addr 0x2002, rdata 0x8001_7FFF -> resp_data 0xFFFF_8001. Same with LHU -> 0x0000_8001.
- SB wdata 0x0000_00AB at addr 0x3001, mem_ready delayed 3 cycles -> mem_valid/addr/wstrb 0010/wdata 0xABAB_ABAB held stable 4 cycles, then resp_valid with data 0.
- LW at addr 0x4002 -> no mem_valid ever, resp_valid one cycle after accept, resp_err 1. resp_ready low for 2 cycles -> response held, req_ready low.
- Load issued, rst_n low in WAIT, rvalid arrives after reset -> all outputs at reset values, no resp_valid.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=8, load never gets rvalid -> resp_valid with resp_err 1 after 8 cycles in WAIT.
